// File: rtl/uart_pkt_pkg.sv
// Purpose: shared state encoding, default sync marker and width helper for the packet decoder.
// Latency: none (types and constants only).
// Backpressure: n/a.
package uart_pkt_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN     = 3'd1,
    PAYLOAD = 3'd2,
    CHECK   = 3'd3,
    DRAIN   = 3'd4
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  // Width needed to hold a length value in the range 0..max_len.
  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/uart_pkt_buffer.sv
// Purpose: MAX_LEN x DATA_BITS payload store, one synchronous write port and one combinational read port.
// Latency: write visible on the cycle after we; read is combinational.
// Backpressure: none; the caller sequences addresses.
module uart_pkt_buffer #(
  parameter int DATA_BITS = 8,
  parameter int MAX_LEN   = 16,
  parameter int AW        = $clog2(MAX_LEN)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [DATA_BITS-1:0] wdata,
  input  logic [AW-1:0]        raddr,
  output logic [DATA_BITS-1:0] rdata
);

  logic [DATA_BITS-1:0] r_mem [MAX_LEN];

  // Payload writes; contents need no reset because nothing reads them before a write.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/uart_pkt_rx.sv
// Purpose: decodes SYNC/LEN/payload/CHK frames from the UART byte stream and replays good payloads (optional gap timeout: UART_PKT_TIMEOUT_EN).
// Latency: first payload byte valid 1 cycle after the CHK strobe; one byte per cycle while out_ready is high.
// Backpressure: out_ready low holds out_data/out_last; bytes arriving while draining are dropped with an overrun pulse.
module uart_pkt_rx
  import uart_pkt_pkg::*;
#(
  parameter int                   DATA_BITS    = 8,
  parameter int                   MAX_LEN      = 16,
  parameter logic [DATA_BITS-1:0] SYNC_BYTE    = DATA_BITS'(SYNC_BYTE_DEF),
  parameter int                   TIMEOUT_CLKS = 1_000_000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_BITS-1:0]         rx_byte,
  input  logic                         rx_cplt,
  output logic [DATA_BITS-1:0]         out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_last,
  output logic [len_w(MAX_LEN)-1:0]    pkt_len,
  output logic                         pkt_ok,
  output logic                         pkt_err,
  output logic                         overrun,
  output logic                         busy
);

  localparam int LW = len_w(MAX_LEN);
  localparam int IW = $clog2(MAX_LEN);
  localparam logic [DATA_BITS-1:0] MAX_LEN_B = DATA_BITS'(MAX_LEN);

  state_t               r_state, w_state_nxt;
  logic                 r_rx_cplt_q;
  logic [LW-1:0]        r_len, w_len_nxt;
  logic [IW-1:0]        r_idx, w_idx_nxt;
  logic [IW-1:0]        r_rd_idx, w_rd_idx_nxt;
  logic [DATA_BITS-1:0] r_csum, w_csum_nxt;
  logic [LW-1:0]        r_pkt_len, w_pkt_len_nxt;
  logic                 r_pkt_ok, w_pkt_ok_nxt;
  logic                 r_pkt_err, w_pkt_err_nxt;
  logic                 r_overrun, w_overrun_nxt;

  logic                 w_stb;
  logic                 w_we;
  logic                 w_idx_last;
  logic                 w_rd_last;
  logic [DATA_BITS-1:0] w_rdata;
  logic                 w_timeout;

  // rx_cplt is high for two cycles per byte; the rising edge marks the byte once.
  assign w_stb      = rx_cplt & ~r_rx_cplt_q;
  assign w_idx_last = (LW'(r_idx) == (r_len - LW'(1)));
  assign w_rd_last  = (LW'(r_rd_idx) == (r_len - LW'(1)));

  uart_pkt_buffer #(
    .DATA_BITS (DATA_BITS),
    .MAX_LEN   (MAX_LEN),
    .AW        (IW)
  ) u_buf (
    .clk   (clk),
    .we    (w_we),
    .waddr (r_idx),
    .wdata (rx_byte),
    .raddr (r_rd_idx),
    .rdata (w_rdata)
  );

`ifdef UART_PKT_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  logic [TW-1:0] r_gap;
  logic          w_in_frame;

  assign w_in_frame = (r_state == LEN) || (r_state == PAYLOAD) || (r_state == CHECK);
  // A strobe always wins over an expiring gap, so a late-but-present byte is still taken.
  assign w_timeout  = w_in_frame && !w_stb && (r_gap == TW'(TIMEOUT_CLKS - 1));

  // Inter-byte gap counter: runs only mid-frame, restarts on every byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gap <= '0;
    end else if (w_stb || !w_in_frame || w_timeout) begin
      r_gap <= '0;
    end else begin
      r_gap <= r_gap + TW'(1);
    end
  end
`else
  // Timeout parameter is accepted for interface compatibility but has no effect here.
  localparam int unused_timeout_clks = TIMEOUT_CLKS;
  assign w_timeout = 1'b0;
`endif

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_rx_cplt_q <= 1'b0;
      r_len       <= '0;
      r_idx       <= '0;
      r_rd_idx    <= '0;
      r_csum      <= '0;
      r_pkt_len   <= '0;
      r_pkt_ok    <= 1'b0;
      r_pkt_err   <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rx_cplt_q <= rx_cplt;
      r_len       <= w_len_nxt;
      r_idx       <= w_idx_nxt;
      r_rd_idx    <= w_rd_idx_nxt;
      r_csum      <= w_csum_nxt;
      r_pkt_len   <= w_pkt_len_nxt;
      r_pkt_ok    <= w_pkt_ok_nxt;
      r_pkt_err   <= w_pkt_err_nxt;
      r_overrun   <= w_overrun_nxt;
    end
  end

  // Frame parser: next state, counters, checksum and status pulses.
  always_comb begin
    w_state_nxt   = r_state;
    w_len_nxt     = r_len;
    w_idx_nxt     = r_idx;
    w_rd_idx_nxt  = r_rd_idx;
    w_csum_nxt    = r_csum;
    w_pkt_len_nxt = r_pkt_len;
    w_pkt_ok_nxt  = 1'b0;
    w_pkt_err_nxt = 1'b0;
    w_overrun_nxt = 1'b0;
    w_we          = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_stb && (rx_byte == SYNC_BYTE)) begin
          w_state_nxt = LEN;
        end
      end
      LEN: begin
        // A repeated SYNC value here is just an (illegal) length, never a resync.
        if (w_stb) begin
          if ((rx_byte == '0) || (rx_byte > MAX_LEN_B)) begin
            w_pkt_err_nxt = 1'b1;
            w_state_nxt   = IDLE;
          end else begin
            w_len_nxt   = LW'(rx_byte);
            w_csum_nxt  = rx_byte;
            w_idx_nxt   = '0;
            w_state_nxt = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (w_stb) begin
          w_we       = 1'b1;
          w_csum_nxt = r_csum ^ rx_byte;
          if (w_idx_last) begin
            w_state_nxt = CHECK;
          end else begin
            w_idx_nxt = r_idx + IW'(1);
          end
        end
      end
      CHECK: begin
        if (w_stb) begin
          if (rx_byte == r_csum) begin
            w_pkt_ok_nxt  = 1'b1;
            w_pkt_len_nxt = r_len;
            w_rd_idx_nxt  = '0;
            w_state_nxt   = DRAIN;
          end else begin
            w_pkt_err_nxt = 1'b1;
            w_state_nxt   = IDLE;
          end
        end
      end
      DRAIN: begin
        w_overrun_nxt = w_stb;
        if (out_ready) begin
          if (w_rd_last) begin
            w_state_nxt = IDLE;
          end else begin
            w_rd_idx_nxt = r_rd_idx + IW'(1);
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    if (w_timeout) begin
      w_pkt_err_nxt = 1'b1;
      w_state_nxt   = IDLE;
    end
  end

  // Outputs derive from registered state so reset clears them without waiting for a clock.
  assign out_valid = (r_state == DRAIN);
  assign out_data  = out_valid ? w_rdata : '0;
  assign out_last  = out_valid & w_rd_last;
  assign pkt_len   = r_pkt_len;
  assign pkt_ok    = r_pkt_ok;
  assign pkt_err   = r_pkt_err;
  assign overrun   = r_overrun;
  assign busy      = (r_state != IDLE);

endmodule
